// File: rtl/inst_cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package inst_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_LINES      = 8;
  localparam int unsigned DEF_LINE_WORDS = 4;

  function automatic int unsigned off_bits(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Byte-offset bits [1:0] never take part in lookup.
  function automatic int unsigned tag_bits(input int unsigned lines, input int unsigned line_words);
    return 30 - off_bits(line_words) - idx_bits(lines);
  endfunction

endpackage

// File: rtl/inst_cache_array.sv
// Tag/valid/data storage: one combinational read port, one word write port, tag write, clear-all.
module inst_cache_array
  import inst_cache_pkg::*;
#(
  parameter int unsigned LINES      = DEF_LINES,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  localparam int unsigned OW = off_bits(LINE_WORDS),
  localparam int unsigned IW = idx_bits(LINES),
  localparam int unsigned TW = tag_bits(LINES, LINE_WORDS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clear_all,
  input  logic [IW-1:0] rd_index,
  input  logic [OW-1:0] rd_offset,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_word,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_index,
  input  logic [OW-1:0] wr_offset,
  input  logic [31:0]   wr_word,
  input  logic          tag_we,
  input  logic [TW-1:0] tag_wdata,
  input  logic          set_valid
);

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES*LINE_WORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_word  = data_q[{rd_index, rd_offset}];

  // Clear-all wins over a same-cycle tag commit so an invalidate is never lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (tag_we && set_valid) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      data_q[{wr_index, wr_offset}] <= wr_word;
    end
    if (tag_we) begin
      tag_q[wr_index] <= tag_wdata;
    end
  end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with whole-line refill.
// Optional performance counters PERF_HIT/PERF_MISS when INST_CACHE_PERF_EN is defined.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned LINES      = DEF_LINES,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_ROADDR,
  output logic [31:0] INST_RDATA,
  output logic        MMU_WAIT,
  input  logic        INVALIDATE,
  output logic        MEM_ARVALID,
  input  logic        MEM_ARREADY,
  output logic [31:0] MEM_ARADDR,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA
`ifdef INST_CACHE_PERF_EN
  ,
  output logic [31:0] PERF_HIT,
  output logic [31:0] PERF_MISS
`endif
);

  localparam int unsigned OW       = off_bits(LINE_WORDS);
  localparam int unsigned IW       = idx_bits(LINES);
  localparam int unsigned TW       = tag_bits(LINES, LINE_WORDS);
  localparam int unsigned LINE_LSB = OW + 2;

  state_t        state_q, state_d;
  logic [31:0]   line_base_q;
  logic [OW-1:0] beat_q;
  logic          drop_q;

  logic [OW-1:0] req_off;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;

  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  logic [31:0]   rd_word;
  logic          hit;
  logic          miss_start;
  logic          wr_en;
  logic          tag_we;
  logic          resp_fire;

  assign req_off  = INST_RIADDR[OW+1:2];
  assign req_idx  = INST_RIADDR[OW+IW+1:OW+2];
  assign req_tag  = INST_RIADDR[31:OW+IW+2];
  assign fill_idx = line_base_q[OW+IW+1:OW+2];
  assign fill_tag = line_base_q[31:OW+IW+2];

  inst_cache_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .CLK       (CLK),
    .RST       (RST),
    .clear_all (INVALIDATE),
    .rd_index  (req_idx),
    .rd_offset (req_off),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_word   (rd_word),
    .wr_en     (wr_en),
    .wr_index  (fill_idx),
    .wr_offset (beat_q),
    .wr_word   (MEM_RDATA),
    .tag_we    (tag_we),
    .tag_wdata (fill_tag),
    .set_valid (!drop_q && !INVALIDATE)
  );

  assign hit        = rd_valid && (rd_tag == req_tag);
  assign MMU_WAIT   = (state_q != ST_IDLE) || (INST_RDEN && !hit);
  assign MEM_ARADDR = line_base_q;
  assign resp_fire  = (state_q == ST_IDLE) && INST_RDEN && hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    MEM_ARVALID = 1'b0;
    wr_en       = 1'b0;
    tag_we      = 1'b0;
    miss_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (INST_RDEN && !hit) begin
          miss_start = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        MEM_ARVALID = 1'b1;
        if (MEM_ARREADY) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (MEM_RVALID) begin
          wr_en = 1'b1;
          if (beat_q == OW'(LINE_WORDS - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        tag_we  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The drop flag remembers an invalidate that landed mid-refill so DONE leaves the line invalid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      line_base_q <= '0;
      beat_q      <= '0;
      drop_q      <= 1'b0;
    end else begin
      if (miss_start) begin
        line_base_q <= {INST_RIADDR[31:LINE_LSB], {LINE_LSB{1'b0}}};
      end
      if (state_q == ST_REQ && MEM_ARREADY) begin
        beat_q <= '0;
      end else if (wr_en) begin
        beat_q <= beat_q + 1'b1;
      end
      if (state_q != ST_IDLE && state_d == ST_IDLE) begin
        drop_q <= 1'b0;
      end else if (INVALIDATE && state_q != ST_IDLE) begin
        drop_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      INST_RVALID <= 1'b0;
      INST_ROADDR <= '0;
      INST_RDATA  <= '0;
    end else begin
      INST_RVALID <= resp_fire;
      if (resp_fire) begin
        INST_ROADDR <= INST_RIADDR;
        INST_RDATA  <= rd_word;
      end
    end
  end

`ifdef INST_CACHE_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      PERF_HIT  <= '0;
      PERF_MISS <= '0;
    end else begin
      if (resp_fire) begin
        PERF_HIT <= PERF_HIT + 32'd1;
      end
      if (miss_start) begin
        PERF_MISS <= PERF_MISS + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache answering the fetch stage's MMU instruction port. It accepts word requests (INST_RDEN/INST_RIADDR) and returns registered responses (INST_RVALID/INST_ROADDR/INST_RDATA) one cycle after a hit. On a miss it holds MMU_WAIT high and refills the whole line from the memory bus. It sits between the main pipeline's fetch stage and the memory interconnect.

## Interface
- LINES, 8: number of lines; power of 2, 2..64
- LINE_WORDS, 4: 32-bit words per line; power of 2, 2..16
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- INST_RDEN  in  1  fetch request valid this cycle
- INST_RIADDR  in  32  request byte address; bits [1:0] ignored for lookup
- INST_RVALID  out  1  response valid
- INST_ROADDR  out  32  address of the response (echo of INST_RIADDR)
- INST_RDATA  out  32  instruction word
- MMU_WAIT  out  1  cache cannot serve current request; fetch holds PC
- INVALIDATE  in  1  one-cycle pulse; clears all valid bits (FENCE.I)
- MEM_ARVALID  out  1  line read request
- MEM_ARREADY  in  1  memory accepts request
- MEM_ARADDR  out  32  line base address (offset bits zero)
- MEM_RVALID  in  1  read data beat valid
- MEM_RDATA  in  32  read data beat, ascending word order

## Operation
- Address split: offset = [log2(LINE_WORDS)+1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
- hit = valid[index] && tag[index] == request tag.
- FSM: IDLE, REQ, FILL, DONE.
  - IDLE: if INST_RDEN && !hit, latch line base and go to REQ.
  - REQ: MEM_ARVALID=1; on MEM_ARVALID && MEM_ARREADY, go to FILL with beat counter = 0.
  - FILL: each MEM_RVALID writes word[counter] of the target line and increments the counter. The beat where counter == LINE_WORDS-1 moves to DONE.
  - DONE: write the tag. Set valid unless an invalidate was seen during the refill. Return to IDLE.
- MMU_WAIT = (state != IDLE) || (INST_RDEN && !hit). The signal is combinational so fetch holds its PC in the same cycle.
- Response register: INST_RVALID <= (state==IDLE && INST_RDEN && hit). On that edge, INST_ROADDR <= INST_RIADDR and INST_RDATA <= word. When INST_RVALID is 0, INST_ROADDR and INST_RDATA hold their previous values.
- No critical-word-first: data is served only after DONE.
- INVALIDATE:
  - Clears all valid bits next edge and sets the drop flag if state != IDLE. The flag is cleared on entry to IDLE.
  - INVALIDATE coinciding with a hit still produces that hit's response.
- INST_RDEN=0 (fetch flush/stall): no response next cycle. An in-flight refill always runs to completion because bursts are not aborted.
- MEM_RVALID outside FILL is ignored.

## Timing
- Reset values:
  - INST_RVALID=0, INST_ROADDR=0, INST_RDATA=0.
  - MEM_ARVALID=0, MEM_ARADDR=0.
  - state=IDLE, all valid bits=0, drop flag=0.
  - MMU_WAIT follows its equation, so it is 1 if INST_RDEN=1 after reset.
- RST mid-refill returns to IDLE immediately. Memory shares RST, so no stale beats are expected.
- Hit latency: request at cycle N, INST_RVALID at N+1. Back-to-back hits give one response per cycle.
- Miss with ARREADY=1 and consecutive beats (miss at cycle 0):
  - REQ at 1, beats at 2..(1+LINE_WORDS).
  - DONE at 2+LINE_WORDS, hit in IDLE at 3+LINE_WORDS.
  - INST_RVALID at 4+LINE_WORDS (default: cycle 8).
- MEM_ARVALID and MEM_ARADDR stay stable until accepted.

## Configuration
- INST_CACHE_PERF_EN defined:
  - Adds outputs PERF_HIT (32) and PERF_MISS (32), both reset to 0 and wrapping at 2^32.
  - PERF_HIT increments on each cycle that sets INST_RVALID.
  - PERF_MISS increments on each IDLE-to-REQ transition.
- Undefined: these ports and counters do not exist.

## Structure
- Shared package: FSM state enum (IDLE/REQ/FILL/DONE), default LINES/LINE_WORDS, address-split width functions.
- One sub-module, inst_cache_array: tag/valid/data storage with one read port (index, offset) and one word write port plus tag write. Valid clear-all lives inside it.

## Test plan
- Cold miss at 0x2000_0000, ARREADY=1, beats 0x13, 0x93, 0x113, 0x193 -> MMU_WAIT high for cycles 0..6; MEM_ARADDR=0x2000_0000; INST_RVALID at cycle 8 with ROADDR 0x2000_0000, RDATA 0x13.
- Sequential requests 0x2000_0004..0x2000_000C after the fill -> three consecutive responses with matching ROADDR and RDATA 0x93, 0x113, 0x193, and MMU_WAIT=0.
- Conflict: 0x2000_0000 then 0x2000_0080 (same index with defaults) -> second access misses and refills; re-requesting 0x2000_0000 misses again.
- INVALIDATE pulsed mid-FILL for 0x2000_0040 -> the line is not made valid, and the next request to 0x2000_0040 misses again.
- ARREADY held low for 5 cycles, then beats with 1-cycle gaps -> MEM_ARADDR stable, exactly LINE_WORDS beats consumed, correct data returned.
- RST asserted during FILL -> next cycle INST_RVALID=0, MEM_ARVALID=0, and a prior-valid address misses.
